edge_event_capture: RTL

EDGE_EVENT_CAPTURE -- requirements
Module: edge_event_capture

---
 rtl/edge_capture_pkg.sv | 28 ++
 rtl/edge_capture_channel.sv | 62 ++++++
 rtl/edge_event_capture.sv | 96 +++++++++
 3 files changed

// File: rtl/edge_capture_pkg.sv
// Shared constants for the edge event capture block: register addresses,
// per-channel detection mode encodings and the edge-detect helper.
package edge_capture_pkg;

  localparam logic [1:0] ADDR_STATUS   = 2'b00;
  localparam logic [1:0] ADDR_OVERFLOW = 2'b01;
  localparam logic [1:0] ADDR_MODE     = 2'b10;
  localparam logic [1:0] ADDR_IRQ_EN   = 2'b11;

  localparam logic [1:0] MODE_OFF  = 2'b00;
  localparam logic [1:0] MODE_RISE = 2'b01;
  localparam logic [1:0] MODE_FALL = 2'b10;
  localparam logic [1:0] MODE_BOTH = 2'b11;

  function automatic logic edge_detect(input logic [1:0] mode,
                                       input logic       sample,
                                       input logic       history);
    logic hit;
    case (mode)
      MODE_RISE: hit = sample & ~history;
      MODE_FALL: hit = ~sample & history;
      MODE_BOTH: hit = sample ^ history;
      default:   hit = 1'b0;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/edge_capture_channel.sv
// One monitored channel: optional 2-flop synchroniser, history bit, edge
// detect and the sticky STATUS/OVERFLOW bits. EDGE_EVENT_CAPTURE_SYNC_EN adds the synchroniser.
module edge_capture_channel
  import edge_capture_pkg::*;
(
  input  logic       Clock,
  input  logic       Reset,
  input  logic       armed,
  input  logic       in_bit,
  input  logic [1:0] mode,
  input  logic       clr_status,
  input  logic       clr_overflow,
  output logic       status,
  output logic       overflow
);

  logic sample;
  logic history_reg;
  logic hit;
  logic status_next;
  logic overflow_next;

`ifdef EDGE_EVENT_CAPTURE_SYNC_EN
  logic sync_meta_reg;
  logic sync_out_reg;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      sync_meta_reg <= 1'b0;
      sync_out_reg  <= 1'b0;
    end else begin
      sync_meta_reg <= in_bit;
      sync_out_reg  <= sync_meta_reg;
    end
  end

  assign sample = sync_out_reg;
`else
  assign sample = in_bit;
`endif

  // Detection is held off until armed so the history can load after reset.
  assign hit = armed & edge_detect(mode, sample, history_reg);

  // A new edge beats a same-cycle clear; overflow only counts against a bit
  // that stays set through this cycle.
  assign status_next   = hit | (status & ~clr_status);
  assign overflow_next = (hit & status & ~clr_status) | (overflow & ~clr_overflow);

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      history_reg <= 1'b0;
      status      <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      history_reg <= sample;
      status      <= status_next;
      overflow    <= overflow_next;
    end
  end

endmodule

// File: rtl/edge_event_capture.sv
// Edge event capture top: CHANNELS edge-detect channels behind a 4-register
// bus slave. Optional input synchroniser via EDGE_EVENT_CAPTURE_SYNC_EN.
module edge_event_capture
  import edge_capture_pkg::*;
#(
  parameter int CHANNELS = 8,
  parameter int DATA_W   = 32
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic [CHANNELS-1:0] In,
  input  logic                ChipSelect,
  input  logic [1:0]          Address,
  input  logic                Write,
  input  logic                Read,
  input  logic [DATA_W-1:0]   WriteData,
  output logic [DATA_W-1:0]   ReadData,
  output logic                Irq
);

  logic                  armed_reg;
  logic [2*CHANNELS-1:0] mode_reg;
  logic [CHANNELS-1:0]   irq_en_reg;
  logic [CHANNELS-1:0]   status_vec;
  logic [CHANNELS-1:0]   overflow_vec;
  logic [CHANNELS-1:0]   clr_status_vec;
  logic [CHANNELS-1:0]   clr_overflow_vec;
  logic [DATA_W-1:0]     read_next;
  logic                  wr_en;
  logic                  rd_en;

  assign wr_en = ChipSelect & Write;
  assign rd_en = ChipSelect & Read;

  assign clr_status_vec   = (wr_en && Address == ADDR_STATUS)   ? WriteData[CHANNELS-1:0] : '0;
  assign clr_overflow_vec = (wr_en && Address == ADDR_OVERFLOW) ? WriteData[CHANNELS-1:0] : '0;

  generate
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_channel
      edge_capture_channel u_channel (
        .Clock        (Clock),
        .Reset        (Reset),
        .armed        (armed_reg),
        .in_bit       (In[gi]),
        .mode         (mode_reg[2*gi+1:2*gi]),
        .clr_status   (clr_status_vec[gi]),
        .clr_overflow (clr_overflow_vec[gi]),
        .status       (status_vec[gi]),
        .overflow     (overflow_vec[gi])
      );
    end

    if (DATA_W > 2*CHANNELS) begin : g_unused_wdata
      logic unused_wdata;
      assign unused_wdata = ^WriteData[DATA_W-1:2*CHANNELS];
    end
  endgenerate

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      armed_reg  <= 1'b0;
      mode_reg   <= '0;
      irq_en_reg <= '0;
    end else begin
      armed_reg <= 1'b1;
      if (wr_en && Address == ADDR_MODE)
        mode_reg <= WriteData[2*CHANNELS-1:0];
      if (wr_en && Address == ADDR_IRQ_EN)
        irq_en_reg <= WriteData[CHANNELS-1:0];
    end
  end

  // Reads sample the registers before this cycle's update, so a read that
  // coincides with a W1C returns the pre-clear value.
  always_comb begin
    read_next = '0;
    case (Address)
      ADDR_STATUS:   read_next[CHANNELS-1:0]   = status_vec;
      ADDR_OVERFLOW: read_next[CHANNELS-1:0]   = overflow_vec;
      ADDR_MODE:     read_next[2*CHANNELS-1:0] = mode_reg;
      default:       read_next[CHANNELS-1:0]   = irq_en_reg;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      ReadData <= '0;
      Irq      <= 1'b0;
    end else begin
      if (rd_en)
        ReadData <= read_next;
      Irq <= |(status_vec & irq_en_reg);
    end
  end

endmodule
